// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmit and receive paths.
package uart_pkg;

  localparam int DBIT       = 8;
  localparam int SB_TICK    = 32;
  localparam int OVERSAMPLE = 16;

  localparam int SCNT_W = $clog2(SB_TICK);
  localparam int NCNT_W = $clog2(DBIT);

  localparam logic [SCNT_W-1:0] OS_LAST   = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] STOP_LAST = SCNT_W'(SB_TICK - 1);
  localparam logic [NCNT_W-1:0] DBIT_LAST = NCNT_W'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // A divisor below 2 degenerates to one s_tick per clock.
  function automatic logic [9:0] clamp_div(input logic [9:0] n);
    return (n < 10'd2) ? 10'd1 : n;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty flags; read data is presented from the head slot.
module uart_tx_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_wr;
  logic          do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      default: count_next = count;
    endcase
  end

  // Flags are registered from the next count so they line up with the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_top.sv
// UART 8N2 transmitter: byte FIFO, programmable 16x tick generator and serialising FSM.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write_en,
  input  logic [7:0] write_data,
  input  logic [9:0] input_number,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       tx_busy,
  output logic       tx_done
);

  uart_state_t       state;
  uart_state_t       state_next;
  logic [9:0]        div;
  logic [9:0]        div_next;
  logic [9:0]        tick_cnt;
  logic [9:0]        tick_cnt_next;
  logic [SCNT_W-1:0] s_cnt;
  logic [SCNT_W-1:0] s_cnt_next;
  logic [NCNT_W-1:0] n;
  logic [NCNT_W-1:0] n_next;
  logic [DBIT-1:0]   shreg;
  logic [DBIT-1:0]   shreg_next;
  logic [7:0]        fifo_data;
  logic              s_tick;
  logic              pop;
  logic              tx_next;
  logic              tx_busy_next;
  logic              tx_done_next;

  uart_tx_fifo #(
    .AW (FIFO_AW),
    .W  (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (write_en),
    .wr_data (write_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty)
  );

  assign s_tick = (state != IDLE) && (tick_cnt == div - 10'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div      <= 10'd1;
      tick_cnt <= '0;
      s_cnt    <= '0;
      n        <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_next;
      div      <= div_next;
      tick_cnt <= tick_cnt_next;
      s_cnt    <= s_cnt_next;
      n        <= n_next;
      shreg    <= shreg_next;
      tx       <= tx_next;
      tx_busy  <= tx_busy_next;
      tx_done  <= tx_done_next;
    end
  end

  always_comb begin
    state_next    = state;
    div_next      = div;
    s_cnt_next    = s_cnt;
    n_next        = n;
    shreg_next    = shreg;
    pop           = 1'b0;
    tick_cnt_next = (state == IDLE || s_tick) ? 10'd0 : tick_cnt + 10'd1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_next = fifo_data;
          div_next   = clamp_div(input_number);
          s_cnt_next = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == OS_LAST) begin
            s_cnt_next = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_cnt_next = s_cnt + SCNT_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == OS_LAST) begin
            s_cnt_next = '0;
            shreg_next = shreg >> 1;
            if (n == DBIT_LAST) state_next = STOP;
            else                n_next     = n + NCNT_W'(1);
          end else begin
            s_cnt_next = s_cnt + SCNT_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            s_cnt_next = '0;
            state_next = IDLE;
          end else begin
            s_cnt_next = s_cnt + SCNT_W'(1);
          end
        end
      end
    endcase
  end

  // Outputs are decoded from next-state values so the registered copies line up with the state.
  always_comb begin
    tx_busy_next = (state_next != IDLE);
    tx_done_next = (state_next == STOP) && (s_cnt_next == STOP_LAST) &&
                   (tick_cnt_next == div_next - 10'd1);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top: a serial-line monitor decodes frames and checks them against a byte queue.
module tb_uart_tx_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en;
  logic [7:0] write_data;
  logic [9:0] input_number;
  logic       tx;
  logic       full;
  logic       empty;
  logic       tx_busy;
  logic       tx_done;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         frames_seen = 0;
  int         cur_div = 325;
  bit         mon_en = 1'b0;
  logic       prev_tx;
  logic [7:0] rx_byte;
  logic [7:0] exp_q [$];

  uart_tx_top dut (
    .clk          (clk),
    .rst          (rst),
    .write_en     (write_en),
    .write_data   (write_data),
    .input_number (input_number),
    .tx           (tx),
    .full         (full),
    .empty        (empty),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one write for a single clock; accepted bytes join the expected-frame queue.
  task automatic apply_stimulus(input logic [7:0] data, input bit accepted);
    write_en   = 1'b1;
    write_data = data;
    if (accepted) exp_q.push_back(data);
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        t = cyc;
        break;
      end
    end
    check_output("tx_done_seen", 32'(tx_done), 1);
  endtask

  // Line monitor: samples mid-bit and expects tx_done on the very last stop-phase cycle.
  initial begin
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
        repeat (8 * cur_div - 1) @(negedge clk);
        check_output("start_bit", 32'(tx), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (16 * cur_div) @(negedge clk);
          rx_byte[i] = tx;
        end
        repeat (16 * cur_div) @(negedge clk);
        check_output("stop_bit1", 32'(tx), 1);
        repeat (16 * cur_div) @(negedge clk);
        check_output("stop_bit2", 32'(tx), 1);
        repeat (8 * cur_div) @(negedge clk);
        check_output("done_at_frame_end", 32'(tx_done), 1);
        frames_seen++;
        check_output("frame_byte", 32'(rx_byte),
                     (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
      end
      prev_tx = tx;
    end
  end

  initial begin
    int t0, t1, t2, saved, lows, fr;
    rst          = 1'b1;
    write_en     = 1'b0;
    write_data   = 8'h00;
    input_number = 10'd325;

    // Reset
    @(negedge clk);
    check_output("rst_tx", 32'(tx), 1);
    check_output("rst_empty", 32'(empty), 1);
    check_output("rst_full", 32'(full), 0);
    check_output("rst_busy", 32'(tx_busy), 0);
    check_output("rst_done", 32'(tx_done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte at 9600 baud: exact pop latency and frame length
    $display("[TB] single frame 0x0F, div=325");
    mon_en  = 1'b1;
    cur_div = 325;
    saved   = done_cnt;
    apply_stimulus(8'h0F, 1'b1);
    check_output("wr_empty", 32'(empty), 0);
    check_output("pre_pop_busy", 32'(tx_busy), 0);
    @(negedge clk);
    check_output("start_tx", 32'(tx), 0);
    check_output("start_busy", 32'(tx_busy), 1);
    check_output("popped_empty", 32'(empty), 1);
    t0 = cyc;
    wait_done(60000, t1);
    check_output("frame_len_325", t1 - t0, 57199);
    @(negedge clk);
    check_output("after_tx", 32'(tx), 1);
    check_output("after_busy", 32'(tx_busy), 0);
    check_output("done_once", done_cnt - saved, 1);
    check_output("frames_1", frames_seen, 1);

    // Two back-to-back bytes, input_number=0 clamps to one tick per clock
    $display("[TB] pair 0xA5 0x3C, input_number=0");
    input_number = 10'd0;
    cur_div      = 1;
    apply_stimulus(8'hA5, 1'b1);
    apply_stimulus(8'h3C, 1'b1);
    wait_done(300, t1);
    wait_done(300, t2);
    check_output("b2b_gap_div1", t2 - t1, 177);
    @(negedge clk);
    check_output("frames_3", frames_seen, 3);

    // Fill: first byte goes straight to the shifter, 16 more fill the FIFO, the rest drop
    $display("[TB] fill test, div=2");
    input_number = 10'd2;
    cur_div      = 2;
    for (int k = 0; k < 20; k++) begin
      if (k >= 15 && k <= 17) check_output("full_before_wr", 32'(full), 32'(k >= 17));
      apply_stimulus(8'(k), k <= 16);
    end
    check_output("full_after_fill", 32'(full), 1);
    check_output("empty_after_fill", 32'(empty), 0);
    wait_done(800, t1);
    for (int f = 1; f < 17; f++) begin
      wait_done(400, t2);
      check_output("b2b_gap_div2", t2 - t1, 353);
      t1 = t2;
    end
    @(negedge clk);
    check_output("drain_empty", 32'(empty), 1);
    check_output("drain_full", 32'(full), 0);
    check_output("drain_busy", 32'(tx_busy), 0);
    check_output("frames_20", frames_seen, 20);

    // Reset during data bit 3 of 0x55 with a second byte still queued
    $display("[TB] reset mid-frame, div=4");
    mon_en       = 1'b0;
    input_number = 10'd4;
    apply_stimulus(8'h55, 1'b0);
    apply_stimulus(8'h77, 1'b0);
    check_output("abort_start", 32'(tx), 0);
    repeat (280) @(negedge clk);
    check_output("abort_bit3", 32'(tx), 0);
    check_output("abort_queued", 32'(empty), 0);
    saved = done_cnt;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_tx", 32'(tx), 1);
    check_output("abort_empty", 32'(empty), 1);
    check_output("abort_busy", 32'(tx_busy), 0);
    check_output("abort_done", 32'(tx_done), 0);
    lows = 0;
    repeat (1200) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check_output("abort_idle_line", lows, 0);
    check_output("abort_no_done", done_cnt - saved, 0);
    mon_en  = 1'b1;
    cur_div = 4;
    fr      = frames_seen;
    apply_stimulus(8'h3C, 1'b1);
    wait_done(1000, t1);
    @(negedge clk);
    check_output("fresh_frame", frames_seen - fr, 1);

    // input_number=1: bit 7 of 0x80 occupies offsets 128..143; later input_number change is ignored
    $display("[TB] 0x80 at input_number=1");
    input_number = 10'd1;
    cur_div      = 1;
    apply_stimulus(8'h80, 1'b1);
    @(negedge clk);
    check_output("d1_start", 32'(tx), 0);
    input_number = 10'd325;
    for (int o = 1; o <= 176; o++) begin
      @(negedge clk);
      if (o == 127) check_output("d1_bit6", 32'(tx), 0);
      if (o == 128) check_output("d1_bit7_first", 32'(tx), 1);
      if (o == 143) check_output("d1_bit7_last", 32'(tx), 1);
      if (o == 175) check_output("d1_done", 32'(tx_done), 1);
      if (o == 176) check_output("d1_idle", 32'(tx_busy), 0);
    end
    @(negedge clk);
    check_output("frames_22", frames_seen, 22);
    check_output("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
